// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: writeback select, store size, load funct3, FSM states.
// Also holds the access-size helpers used by the top and its alignment unit.
package mem_stage_pkg;

  localparam logic [1:0] OUT_ALU  = 2'b00;
  localparam logic [1:0] OUT_LOAD = 2'b01;
  localparam logic [1:0] OUT_PC4  = 2'b10;
  localparam logic [1:0] OUT_IMM  = 2'b11;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Unknown funct3 codes fall back to a full-word load.
  function automatic logic [1:0] load_size(input logic [2:0] ld_type);
    case (ld_type)
      LD_LB, LD_LBU: load_size = SZ_BYTE;
      LD_LH, LD_LHU: load_size = SZ_HALF;
      default:       load_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables/replicated data, and load lane extraction/extension.
// Purely combinational; a store size of NONE means a load, which always reads the full word.
import mem_stage_pkg::*;
module mem_align (
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [31:0] lane;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        be    = 4'b0001 << st_addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    case (ld_type)
      LD_LB:   ld_value = {{24{lane[7]}}, lane[7:0]};
      LD_LH:   ld_value = {{16{lane[15]}}, lane[15:0]};
      LD_LBU:  ld_value = {24'h0, lane[7:0]};
      LD_LHU:  ld_value = {16'h0, lane[15:0]};
      default: ld_value = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one outstanding request/ack bus access, upstream stall,
// ack timeout, and registered writeback outputs.
import mem_stage_pkg::*;
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Src_pc_i,
  input  logic [31:0] Src_alu_i,
  input  logic [31:0] Src_rs2_i,
  input  logic [31:0] Src_imm_i,
  input  logic [4:0]  Src_rd_i,
  input  logic [1:0]  Inst_mem_out_sel_i,
  input  logic [1:0]  Inst_mem_we_i,
  input  logic [2:0]  Inst_mem_rd_sel_i,
  input  logic        Inst_wb_we_i,
  input  logic [7:0]  Exe_tracker,
  output logic        Dmem_req_o,
  output logic        Dmem_we_o,
  output logic [31:0] Dmem_addr_o,
  output logic [3:0]  Dmem_be_o,
  output logic [31:0] Dmem_wdata_o,
  input  logic        Dmem_ack_i,
  input  logic [31:0] Dmem_rdata_i,
  output logic        Stall_o,
  output logic [31:0] Src_wb_data_o,
  output logic [4:0]  Src_rd_o,
  output logic        Inst_wb_we_o,
  output logic [7:0]  Mem_tracker,
  output logic        Misalign_o,
  output logic        Bus_err_o
);

  // Timeout fires in the BUSY cycle whose increment would make the count reach ACK_TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [0:0]  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        busy, mem_op, capture;
  logic [1:0]  size_now;
  logic [31:0] sel_val, wdata_now, load_val;
  logic [3:0]  be_now;

  logic [31:0] req_addr_reg, req_wdata_reg, req_val_reg;
  logic [3:0]  req_be_reg;
  logic [1:0]  req_lane_reg;
  logic [2:0]  req_ld_type_reg;
  logic [4:0]  req_rd_reg;
  logic [7:0]  req_trk_reg;
  logic        req_we_reg, req_load_reg, req_wb_we_reg;

  logic [31:0] wb_data_reg, wb_data_next;
  logic [4:0]  wb_rd_reg, wb_rd_next;
  logic [7:0]  wb_trk_reg, wb_trk_next;
  logic        wb_we_reg, wb_we_next;
  logic        misalign_reg, misalign_next, bus_err_reg, bus_err_next;

  mem_align u_align (
    .st_addr_lo (Src_alu_i[1:0]),
    .st_size    (Inst_mem_we_i),
    .st_data    (Src_rs2_i),
    .be         (be_now),
    .wdata      (wdata_now),
    .ld_addr_lo (req_lane_reg),
    .ld_type    (req_ld_type_reg),
    .ld_rdata   (Dmem_rdata_i),
    .ld_value   (load_val)
  );

  assign busy     = (state_reg == ST_BUSY);
  assign mem_op   = (Inst_mem_out_sel_i == OUT_LOAD) || (Inst_mem_we_i != SZ_NONE);
  assign size_now = (Inst_mem_we_i != SZ_NONE) ? Inst_mem_we_i : load_size(Inst_mem_rd_sel_i);

  always_comb begin
    case (Inst_mem_out_sel_i)
      OUT_ALU: sel_val = Src_alu_i;
      OUT_PC4: sel_val = Src_pc_i + 32'd4;
      OUT_IMM: sel_val = Src_imm_i;
      default: sel_val = 32'h0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    capture       = 1'b0;
    Stall_o       = 1'b0;
    wb_data_next  = 32'h0;
    wb_rd_next    = 5'h0;
    wb_we_next    = 1'b0;
    wb_trk_next   = 8'h0;
    misalign_next = 1'b0;
    bus_err_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!mem_op) begin
          wb_data_next = sel_val;
          wb_rd_next   = Src_rd_i;
          wb_we_next   = Inst_wb_we_i;
          wb_trk_next  = Exe_tracker;
        end else if (is_misaligned(size_now, Src_alu_i[1:0])) begin
          misalign_next = 1'b1;
        end else begin
          capture    = 1'b1;
          state_next = ST_BUSY;
          cnt_next   = 8'h0;
          Stall_o    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (Dmem_ack_i) begin
          state_next = ST_IDLE;
          // Stores only produce a writeback when the instruction also writes rd.
          if (req_load_reg || req_wb_we_reg) begin
            wb_data_next = req_load_reg ? load_val : req_val_reg;
            wb_rd_next   = req_rd_reg;
            wb_we_next   = req_wb_we_reg;
            wb_trk_next  = req_trk_reg;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = ST_IDLE;
          bus_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          Stall_o  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 8'h0;
      wb_data_reg  <= 32'h0;
      wb_rd_reg    <= 5'h0;
      wb_we_reg    <= 1'b0;
      wb_trk_reg   <= 8'h0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wb_data_reg  <= wb_data_next;
      wb_rd_reg    <= wb_rd_next;
      wb_we_reg    <= wb_we_next;
      wb_trk_reg   <= wb_trk_next;
      misalign_reg <= misalign_next;
      bus_err_reg  <= bus_err_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_addr_reg    <= 32'h0;
      req_lane_reg    <= 2'b00;
      req_be_reg      <= 4'h0;
      req_wdata_reg   <= 32'h0;
      req_we_reg      <= 1'b0;
      req_load_reg    <= 1'b0;
      req_ld_type_reg <= 3'b000;
      req_rd_reg      <= 5'h0;
      req_wb_we_reg   <= 1'b0;
      req_trk_reg     <= 8'h0;
      req_val_reg     <= 32'h0;
    end else if (capture) begin
      req_addr_reg    <= {Src_alu_i[31:2], 2'b00};
      req_lane_reg    <= Src_alu_i[1:0];
      req_be_reg      <= be_now;
      req_wdata_reg   <= wdata_now;
      req_we_reg      <= (Inst_mem_we_i != SZ_NONE);
      req_load_reg    <= (Inst_mem_out_sel_i == OUT_LOAD);
      req_ld_type_reg <= Inst_mem_rd_sel_i;
      req_rd_reg      <= Src_rd_i;
      req_wb_we_reg   <= Inst_wb_we_i;
      req_trk_reg     <= Exe_tracker;
      req_val_reg     <= sel_val;
    end
  end

  assign Dmem_req_o    = busy;
  assign Dmem_we_o     = busy & req_we_reg;
  assign Dmem_addr_o   = busy ? req_addr_reg : 32'h0;
  assign Dmem_be_o     = busy ? req_be_reg : 4'h0;
  assign Dmem_wdata_o  = busy ? req_wdata_reg : 32'h0;
  assign Src_wb_data_o = wb_data_reg;
  assign Src_rd_o      = wb_rd_reg;
  assign Inst_wb_we_o  = wb_we_reg;
  assign Mem_tracker   = wb_trk_reg;
  assign Misalign_o    = misalign_reg;
  assign Bus_err_o     = bus_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops against a
// byte-level reference model of loads, stores, stalls, misalignment and timeout.
module tb_mem_stage;
  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Src_pc_i, Src_alu_i, Src_rs2_i, Src_imm_i;
  logic [4:0]  Src_rd_i;
  logic [1:0]  Inst_mem_out_sel_i, Inst_mem_we_i;
  logic [2:0]  Inst_mem_rd_sel_i;
  logic        Inst_wb_we_i;
  logic [7:0]  Exe_tracker;
  logic        Dmem_req_o, Dmem_we_o, Dmem_ack_i;
  logic [31:0] Dmem_addr_o, Dmem_wdata_o, Dmem_rdata_i;
  logic [3:0]  Dmem_be_o;
  logic        Stall_o, Inst_wb_we_o, Misalign_o, Bus_err_o;
  logic [31:0] Src_wb_data_o;
  logic [4:0]  Src_rd_o;
  logic [7:0]  Mem_tracker;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Src_pc_i(Src_pc_i), .Src_alu_i(Src_alu_i),
    .Src_rs2_i(Src_rs2_i), .Src_imm_i(Src_imm_i), .Src_rd_i(Src_rd_i),
    .Inst_mem_out_sel_i(Inst_mem_out_sel_i), .Inst_mem_we_i(Inst_mem_we_i),
    .Inst_mem_rd_sel_i(Inst_mem_rd_sel_i), .Inst_wb_we_i(Inst_wb_we_i),
    .Exe_tracker(Exe_tracker), .Dmem_req_o(Dmem_req_o), .Dmem_we_o(Dmem_we_o),
    .Dmem_addr_o(Dmem_addr_o), .Dmem_be_o(Dmem_be_o), .Dmem_wdata_o(Dmem_wdata_o),
    .Dmem_ack_i(Dmem_ack_i), .Dmem_rdata_i(Dmem_rdata_i), .Stall_o(Stall_o),
    .Src_wb_data_o(Src_wb_data_o), .Src_rd_o(Src_rd_o), .Inst_wb_we_o(Inst_wb_we_o),
    .Mem_tracker(Mem_tracker), .Misalign_o(Misalign_o), .Bus_err_o(Bus_err_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc, alu, rs2, imm;
    logic [4:0]  rd;
    logic [1:0]  out_sel, mwe;
    logic [2:0]  rd_sel;
    logic        wb_we;
    logic [7:0]  trk;
  } op_t;

  typedef struct {
    int          stall_cyc, req_cyc, misal, berr;
    logic [31:0] addr, wdata, wb_data;
    logic [3:0]  be;
    logic        dwe, unstable, hung, wb_we;
    logic [4:0]  rd;
    logic [7:0]  trk;
  } res_t;

  function automatic op_t nop_op();
    op_t n;
    n = '{default:'0};
    return n;
  endfunction

  task automatic drive(input op_t op);
    Src_pc_i = op.pc; Src_alu_i = op.alu; Src_rs2_i = op.rs2; Src_imm_i = op.imm;
    Src_rd_i = op.rd; Inst_mem_out_sel_i = op.out_sel; Inst_mem_we_i = op.mwe;
    Inst_mem_rd_sel_i = op.rd_sel; Inst_wb_we_i = op.wb_we; Exe_tracker = op.trk;
  endtask

  // Reference: what the stage should do with one instruction, from the access rules alone.
  function automatic res_t model(input op_t op, input int ack_after, input logic [31:0] rdata);
    res_t e;
    int nbytes, off;
    logic is_store, is_mem;
    logic [31:0] v, lane;
    e = '{default:'0};
    is_store = (op.mwe != 2'b00);
    is_mem   = is_store || (op.out_sel == 2'b01);
    off      = int'(op.alu[1:0]);
    if (is_store) nbytes = (op.mwe == 2'b01) ? 1 : (op.mwe == 2'b10) ? 2 : 4;
    else if (op.rd_sel == 3'd0 || op.rd_sel == 3'd4) nbytes = 1;
    else if (op.rd_sel == 3'd1 || op.rd_sel == 3'd5) nbytes = 2;
    else nbytes = 4;
    case (op.out_sel)
      2'b00:   v = op.alu;
      2'b10:   v = op.pc + 32'd4;
      2'b11:   v = op.imm;
      default: v = 32'h0;
    endcase
    if (!is_mem) begin
      e.wb_data = v; e.rd = op.rd; e.wb_we = op.wb_we; e.trk = op.trk;
      return e;
    end
    if ((off % nbytes) != 0) begin
      e.misal = 1;
      return e;
    end
    e.addr = op.alu - 32'(off);
    e.dwe  = is_store;
    e.be   = is_store ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
    if (nbytes == 1)      e.wdata = 32'(op.rs2[7:0]) * 32'h0101_0101;
    else if (nbytes == 2) e.wdata = 32'(op.rs2[15:0]) * 32'h0001_0001;
    else                  e.wdata = op.rs2;
    if (ack_after >= TO) begin
      e.stall_cyc = TO; e.req_cyc = TO; e.berr = 1;
      return e;
    end
    e.stall_cyc = ack_after + 1;
    e.req_cyc   = ack_after + 1;
    if (op.out_sel == 2'b01) begin
      lane = rdata >> (8 * off);
      if (nbytes == 1) begin
        v = lane & 32'hFF;
        if (op.rd_sel == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (nbytes == 2) begin
        v = lane & 32'hFFFF;
        if (op.rd_sel == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = rdata;
      end
      e.wb_data = v; e.rd = op.rd; e.wb_we = op.wb_we; e.trk = op.trk;
    end else if (op.wb_we) begin
      e.wb_data = v; e.rd = op.rd; e.wb_we = 1'b1; e.trk = op.trk;
    end
    return e;
  endfunction

  // Presents one instruction, plays the memory side, and records what the DUT did.
  task automatic run_op(input op_t op, input int ack_after, input logic [31:0] rdata, output res_t o);
    logic stall_now;
    bit done;
    o = '{default:'0};
    done = 0;
    @(negedge Clk);
    drive(op);
    Dmem_ack_i = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      Dmem_rdata_i = $urandom;
      #1;
      if (Dmem_req_o) begin
        if (o.req_cyc == 0) begin
          o.addr = Dmem_addr_o; o.be = Dmem_be_o; o.wdata = Dmem_wdata_o; o.dwe = Dmem_we_o;
        end else if (Dmem_addr_o !== o.addr || Dmem_be_o !== o.be ||
                     Dmem_wdata_o !== o.wdata || Dmem_we_o !== o.dwe) begin
          o.unstable = 1'b1;
        end
        if (o.req_cyc == ack_after) begin
          Dmem_ack_i = 1'b1; Dmem_rdata_i = rdata;
        end
        o.req_cyc++;
      end
      #1;
      stall_now = Stall_o;
      if (stall_now) o.stall_cyc++;
      @(posedge Clk); #1;
      Dmem_ack_i = 1'b0;
      if (Misalign_o) o.misal++;
      if (Bus_err_o) o.berr++;
      if (!stall_now) begin
        o.wb_data = Src_wb_data_o; o.rd = Src_rd_o; o.wb_we = Inst_wb_we_o; o.trk = Mem_tracker;
        done = 1;
        break;
      end
      @(negedge Clk);
    end
    if (!done) o.hung = 1'b1;
    @(negedge Clk);
    drive(nop_op());
    @(posedge Clk); #1;
    if (Misalign_o) o.misal++;
    if (Bus_err_o) o.berr++;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Dmem_ack_i = 1'b0; Dmem_rdata_i = 32'h0;
    drive(nop_op());
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++;
    if ({Src_wb_data_o, Src_rd_o, Inst_wb_we_o, Mem_tracker, Misalign_o, Bus_err_o} !== '0) begin
      n_bad++; $display("FAIL reset_regs got=%h/%h/%b/%h exp=0", Src_wb_data_o, Src_rd_o, Inst_wb_we_o, Mem_tracker);
    end
    n_cmp++;
    if ({Dmem_req_o, Stall_o, Dmem_we_o, Dmem_addr_o, Dmem_be_o, Dmem_wdata_o} !== '0) begin
      n_bad++; $display("FAIL reset_bus req=%b stall=%b addr=%h exp=0", Dmem_req_o, Stall_o, Dmem_addr_o);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_alu_passthrough();
    op_t op; res_t o;
    op = nop_op(); op.alu = 32'h1234_5678; op.rd = 5'd5; op.wb_we = 1'b1; op.trk = 8'h11;
    run_op(op, 0, 32'h0, o);
    n_cmp++; if (o.wb_data !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_data got=%h exp=12345678", o.wb_data); end
    n_cmp++; if (o.rd !== 5'd5 || o.wb_we !== 1'b1 || o.trk !== 8'h11) begin
      n_bad++; $display("FAIL alu_ctl got rd=%0d we=%b trk=%h exp 5/1/11", o.rd, o.wb_we, o.trk); end
    n_cmp++; if (o.stall_cyc != 0 || o.req_cyc != 0) begin
      n_bad++; $display("FAIL alu_stall got stall=%0d req=%0d exp 0/0", o.stall_cyc, o.req_cyc); end
    $display("alu passthrough wb=%h", o.wb_data);
  endtask

  task automatic test_load();
    op_t op; res_t o;
    op = nop_op(); op.out_sel = 2'b01; op.alu = 32'h103; op.rd_sel = 3'b000;
    op.rd = 5'd7; op.wb_we = 1'b1; op.trk = 8'h21;
    run_op(op, 0, 32'h80FF_0000, o);
    n_cmp++; if (o.addr !== 32'h100 || o.be !== 4'hF) begin
      n_bad++; $display("FAIL lb_req got addr=%h be=%h exp 100/f", o.addr, o.be); end
    n_cmp++; if (o.stall_cyc != 1) begin n_bad++; $display("FAIL lb_stall got=%0d exp=1", o.stall_cyc); end
    n_cmp++; if (o.wb_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got=%h exp=ffffff80", o.wb_data); end
    n_cmp++; if (o.rd !== 5'd7 || o.trk !== 8'h21 || o.wb_we !== 1'b1) begin
      n_bad++; $display("FAIL lb_ctl got rd=%0d trk=%h we=%b exp 7/21/1", o.rd, o.trk, o.wb_we); end
    $display("lb 0x103 wb=%h", o.wb_data);
    op.rd_sel = 3'b100;
    run_op(op, 0, 32'h80FF_0000, o);
    n_cmp++; if (o.wb_data !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_data got=%h exp=00000080", o.wb_data); end
    $display("lbu 0x103 wb=%h", o.wb_data);
  endtask

  task automatic test_store();
    op_t op; res_t o;
    op = nop_op(); op.mwe = 2'b10; op.alu = 32'h202; op.rs2 = 32'hABCD_BEEF; op.rd = 5'd4;
    run_op(op, 3, 32'h0, o);
    n_cmp++; if (o.be !== 4'b1100 || o.wdata !== 32'hBEEF_BEEF || o.dwe !== 1'b1 || o.addr !== 32'h200) begin
      n_bad++; $display("FAIL sh_req got be=%b wdata=%h we=%b addr=%h exp 1100/beefbeef/1/200", o.be, o.wdata, o.dwe, o.addr); end
    n_cmp++; if (o.unstable !== 1'b0) begin n_bad++; $display("FAIL sh_stable got unstable=%b exp=0", o.unstable); end
    n_cmp++; if (o.stall_cyc != 4 || o.req_cyc != 4) begin
      n_bad++; $display("FAIL sh_stall got stall=%0d req=%0d exp 4/4", o.stall_cyc, o.req_cyc); end
    n_cmp++; if (o.wb_we !== 1'b0 || o.wb_data !== 32'h0 || o.rd !== 5'd0) begin
      n_bad++; $display("FAIL sh_bubble got we=%b data=%h rd=%0d exp 0/0/0", o.wb_we, o.wb_data, o.rd); end
    $display("sh 0x202 be=%b wdata=%h", o.be, o.wdata);
  endtask

  task automatic test_misalign();
    op_t op; res_t o;
    op = nop_op(); op.out_sel = 2'b01; op.rd_sel = 3'b010; op.alu = 32'h301; op.wb_we = 1'b1; op.rd = 5'd8;
    run_op(op, 0, 32'h0, o);
    n_cmp++; if (o.req_cyc != 0 || o.stall_cyc != 0) begin
      n_bad++; $display("FAIL mis_req got req=%0d stall=%0d exp 0/0", o.req_cyc, o.stall_cyc); end
    n_cmp++; if (o.misal != 1) begin n_bad++; $display("FAIL mis_pulse got cycles=%0d exp=1", o.misal); end
    n_cmp++; if (o.wb_we !== 1'b0) begin n_bad++; $display("FAIL mis_wbwe got=%b exp=0", o.wb_we); end
    $display("lw 0x301 misalign cycles=%0d", o.misal);
  endtask

  task automatic test_timeout();
    op_t op, late; res_t o;
    op = nop_op(); op.out_sel = 2'b01; op.rd_sel = 3'b010; op.alu = 32'h400; op.wb_we = 1'b1; op.rd = 5'd2;
    run_op(op, 1000, 32'h0, o);
    n_cmp++; if (o.hung !== 1'b0) begin n_bad++; $display("FAIL to_hang got hung=%b exp=0", o.hung); end
    n_cmp++; if (o.berr != 1) begin n_bad++; $display("FAIL to_pulse got cycles=%0d exp=1", o.berr); end
    n_cmp++; if (o.req_cyc != TO || o.stall_cyc != TO) begin
      n_bad++; $display("FAIL to_len got req=%0d stall=%0d exp %0d/%0d", o.req_cyc, o.stall_cyc, TO, TO); end
    n_cmp++; if (o.wb_we !== 1'b0) begin n_bad++; $display("FAIL to_wbwe got=%b exp=0", o.wb_we); end
    late = nop_op(); late.alu = 32'h5555_AAAA; late.wb_we = 1'b1; late.rd = 5'd3; late.trk = 8'h42;
    @(negedge Clk);
    drive(late);
    Dmem_ack_i = 1'b1; Dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (Dmem_req_o !== 1'b0 || Stall_o !== 1'b0) begin
      n_bad++; $display("FAIL late_ack_bus got req=%b stall=%b exp 0/0", Dmem_req_o, Stall_o); end
    @(posedge Clk); #1;
    Dmem_ack_i = 1'b0;
    n_cmp++; if (Src_wb_data_o !== 32'h5555_AAAA || Src_rd_o !== 5'd3) begin
      n_bad++; $display("FAIL late_ack_wb got=%h rd=%0d exp 5555aaaa/3", Src_wb_data_o, Src_rd_o); end
    $display("timeout req=%0d berr=%0d", o.req_cyc, o.berr);
  endtask

  task automatic test_reset_mid_busy();
    op_t op; res_t o;
    op = nop_op(); op.alu = 32'hCAFE_0001; op.rd = 5'd9; op.wb_we = 1'b1; op.trk = 8'h77;
    @(negedge Clk); drive(op);
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    n_cmp++; if ({Src_wb_data_o, Src_rd_o, Inst_wb_we_o, Mem_tracker} !== '0) begin
      n_bad++; $display("FAIL async_rst_wb got=%h rd=%0d exp 0", Src_wb_data_o, Src_rd_o); end
    @(negedge Clk); Reset = 1'b0;
    op = nop_op(); op.out_sel = 2'b01; op.rd_sel = 3'b010; op.alu = 32'h500; op.wb_we = 1'b1; op.rd = 5'd6;
    @(negedge Clk); drive(op);
    @(posedge Clk); #1;
    n_cmp++; if (Dmem_req_o !== 1'b1) begin n_bad++; $display("FAIL busy_req got=%b exp=1", Dmem_req_o); end
    drive(nop_op());
    Reset = 1'b1;
    #1;
    n_cmp++; if (Dmem_req_o !== 1'b0 || Stall_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy got req=%b stall=%b exp 0/0", Dmem_req_o, Stall_o); end
    @(negedge Clk);
    Dmem_ack_i = 1'b1; Dmem_rdata_i = 32'h1357_9BDF;
    @(posedge Clk); #1;
    n_cmp++; if (Inst_wb_we_o !== 1'b0 || Src_wb_data_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_ack got we=%b data=%h exp 0/0", Inst_wb_we_o, Src_wb_data_o); end
    @(negedge Clk);
    Dmem_ack_i = 1'b0; Reset = 1'b0;
    op = nop_op(); op.out_sel = 2'b01; op.rd_sel = 3'b101; op.alu = 32'h602; op.wb_we = 1'b1; op.rd = 5'd10;
    run_op(op, 1, 32'h1234_ABCD, o);
    n_cmp++; if (o.wb_data !== 32'h0000_1234 || o.stall_cyc != 2) begin
      n_bad++; $display("FAIL post_rst_lhu got=%h stall=%0d exp 00001234/2", o.wb_data, o.stall_cyc); end
    $display("post-reset lhu wb=%h", o.wb_data);
  endtask

  task automatic test_random();
    op_t op; res_t o, e;
    int kind, ack_after, s;
    logic [31:0] rdata;
    for (int n = 0; n < 60; n++) begin
      op = nop_op();
      op.pc = $urandom; op.alu = $urandom; op.rs2 = $urandom; op.imm = $urandom;
      op.rd = 5'($urandom); op.wb_we = 1'($urandom); op.trk = 8'($urandom);
      kind = $urandom_range(0, 2);
      s = $urandom_range(0, 2);
      op.out_sel = (s == 0) ? 2'b00 : 2'(s + 1);
      if (kind == 1) begin op.out_sel = 2'b01; op.rd_sel = 3'($urandom_range(0, 7)); end
      if (kind == 2) op.mwe = 2'($urandom_range(1, 3));
      if (kind != 0 && $urandom_range(0, 3) != 0) op.alu[1:0] = 2'b00;
      ack_after = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 4);
      rdata = $urandom;
      e = model(op, ack_after, rdata);
      run_op(op, ack_after, rdata, o);
      n_cmp++; if (o.wb_data !== e.wb_data) begin n_bad++; $display("FAIL rnd%0d_data got=%h exp=%h", n, o.wb_data, e.wb_data); end
      n_cmp++; if (o.rd !== e.rd || o.wb_we !== e.wb_we || o.trk !== e.trk) begin
        n_bad++; $display("FAIL rnd%0d_ctl got %0d/%b/%h exp %0d/%b/%h", n, o.rd, o.wb_we, o.trk, e.rd, e.wb_we, e.trk); end
      n_cmp++; if (o.stall_cyc != e.stall_cyc || o.req_cyc != e.req_cyc || o.hung) begin
        n_bad++; $display("FAIL rnd%0d_timing got stall=%0d req=%0d exp %0d/%0d", n, o.stall_cyc, o.req_cyc, e.stall_cyc, e.req_cyc); end
      n_cmp++; if (o.misal != e.misal || o.berr != e.berr) begin
        n_bad++; $display("FAIL rnd%0d_pulse got mis=%0d berr=%0d exp %0d/%0d", n, o.misal, o.berr, e.misal, e.berr); end
      if (e.req_cyc > 0) begin
        n_cmp++; if (o.addr !== e.addr || o.be !== e.be || o.dwe !== e.dwe || o.unstable) begin
          n_bad++; $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b exp %h/%b/%b", n, o.addr, o.be, o.dwe, e.addr, e.be, e.dwe); end
        if (e.dwe) begin
          n_cmp++; if (o.wdata !== e.wdata) begin n_bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, o.wdata, e.wdata); end
        end
      end
      $display("op%0d sel=%0d we=%0d f3=%0d addr=%h ack@%0d wb=%h rd=%0d wbwe=%b", n, op.out_sel, op.mwe,
               op.rd_sel, op.alu, ack_after, o.wb_data, o.rd, o.wb_we);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of writeback.
- Consumes the execute stage's registered outputs and performs byte/half/word loads and stores over a request/acknowledge data-memory bus.
- Stalls the pipeline while an access is outstanding.
- Selects the writeback value and registers it with rd, write-enable and tracker for the writeback stage.

Parameters:
- ACK_TIMEOUT, 15, maximum cycles in BUSY without Dmem_ack_i before the access is abandoned (range 1..255).

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Src_pc_i  in  32  instruction PC
- Src_alu_i  in  32  ALU result (effective address for loads/stores)
- Src_rs2_i  in  32  store data
- Src_imm_i  in  32  immediate (LUI value)
- Src_rd_i  in  5  destination register
- Inst_mem_out_sel_i  in  2  writeback select: 00 ALU, 01 load data, 10 PC+4, 11 imm
- Inst_mem_we_i  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- Inst_mem_rd_sel_i  in  3  load type (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- Inst_wb_we_i  in  1  register-file write enable
- Exe_tracker  in  8  instruction ID tag
- Dmem_req_o  out  1  bus request
- Dmem_we_o  out  1  1 = store
- Dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- Dmem_be_o  out  4  byte enables
- Dmem_wdata_o  out  32  lane-replicated store data
- Dmem_ack_i  in  1  access complete; rdata valid the same cycle
- Dmem_rdata_i  in  32  read word
- Stall_o  out  1  upstream must hold its outputs
- Src_wb_data_o  out  32  registered writeback value
- Src_rd_o  out  5  registered rd
- Inst_wb_we_o  out  1  registered write enable
- Mem_tracker  out  8  registered ID tag
- Misalign_o  out  1  one-cycle pulse: misaligned access dropped
- Bus_err_o  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (async, active-high): every registered output is 0, state is IDLE, timeout counter is 0. While state is IDLE and no memory op is presented, combinational outputs Dmem_req_o, Stall_o, Dmem_* are also 0.
- Memory op = (Inst_mem_out_sel_i==01) or (Inst_mem_we_i!=00).
- Misaligned means either:
  - a half access with addr[0]=1, or
  - a word access with addr[1:0]!=0.
- FSM states: IDLE, BUSY.
- IDLE, non-memory op:
  - Outputs registered next edge (1-cycle latency). Stall_o=0.
  - wb_data by out_sel: ALU → Src_alu_i; PC+4 → Src_pc_i+4 (mod 2^32); imm → Src_imm_i.
- IDLE, memory op, aligned:
  - Capture address, be, wdata, we, load type, rd, wb_we and tracker into request registers.
  - Go to BUSY. Stall_o=1 this cycle.
  - Writeback outputs are a bubble: wb_we=0, tracker=0, data=0, rd=0.
- IDLE, memory op, misaligned:
  - No request. Misalign_o pulses next edge.
  - Writeback bubble is registered. Stall_o=0.
- BUSY:
  - Dmem_req_o=1 and all Dmem_* outputs held stable from the captured registers until ack.
  - On Dmem_ack_i: register the result, go to IDLE, Stall_o=0 this cycle so upstream advances. Minimum memory-op latency is 2 cycles.
  - Without ack: Stall_o=1, counter increments, bubble is registered.
  - When the counter reaches ACK_TIMEOUT without ack: drop the access (bubble), pulse Bus_err_o, go to IDLE, Stall_o=0.
- Counter clears on entering BUSY.
- A late ack arriving in IDLE is ignored.
- Stores:
  - Byte: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - Word: be=1111.
  - Store completion registers a bubble unless captured wb_we=1.
- Loads: be=1111. The selected lane is shifted by addr[1:0] and sign- or zero-extended per load type. Result is registered with captured rd/wb_we/tracker.
- Ack and Reset in the same cycle: Reset wins and no result is registered.
- Reset mid-BUSY: the request is abandoned immediately.

Decomposition:
- Shared package: out_sel encodings, store-size encodings, load funct3 codes, and FSM state encoding.
- One sub-module, mem_align: pure combinational.
  - Store path: addr[1:0], size and rs2 → be and wdata.
  - Load path: addr[1:0], load type and rdata → extended load value.

Test Plan:
- ALU passthrough: out_sel=00, alu=0x1234_5678, rd=5, wb_we=1, tracker=0x11 → next edge wb_data=0x12345678, rd=5, wb_we=1, tracker=0x11; Stall_o never high.
- LB with 2-cycle ack: alu=0x103, rdata=0x80FF_0000 acked in the first BUSY cycle → Dmem_addr_o=0x100, be=1111; Stall high 1 cycle; wb_data=0xFFFF_FF80. LBU of the same access → 0x0000_0080.
- SH to 0x202, rs2=0xABCD_BEEF, ack after 3 BUSY cycles → be=1100, wdata=0xBEEF_BEEF; request held stable; Stall high 4 cycles; bubble written.
- Misaligned LW at 0x301 → no Dmem_req_o, Misalign_o pulses 1 cycle, wb_we=0, Stall_o=0.
- Timeout with ACK_TIMEOUT=15 and no ack → Bus_err_o pulses once after 15 BUSY cycles, return to IDLE; a late ack is ignored.
- Reset asserted mid-BUSY → all outputs 0 asynchronously, Dmem_req_o=0; the next instruction after reset release is handled normally.
